// File: rtl/gpio_checkpoint_seq.sv
// Checkpoint sequencer: matches firmware status on obs_hi against a programmed table
// and answers on resp_lo after a per-step delay. Define CHKSEQ_STABLE_EN for 2-edge match filtering.
module gpio_checkpoint_seq #(
    parameter int CHK_W = 8,
    parameter int DEPTH = 16,
    parameter int DLY_W = 12,
    parameter int TMO_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [CHK_W-1:0]           prog_expect,
    input  logic [CHK_W-1:0]           prog_resp,
    input  logic [DLY_W-1:0]           prog_delay,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic [TMO_W-1:0]           timeout,
    input  logic                       start,
    input  logic [CHK_W-1:0]           obs_hi,
    output logic [CHK_W-1:0]           resp_lo,
    output logic                       resp_oe,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic [$clog2(DEPTH)-1:0]   fail_step,
    output logic [$clog2(DEPTH)-1:0]   step
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]      NUM_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      NUM_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]    STEP_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]    STEP_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [DLY_W-1:0] DLY_ZERO  = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] DLY_ONE   = {{(DLY_W-1){1'b0}}, 1'b1};
    localparam logic [CHK_W-1:0] CHK_ZERO  = {CHK_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_MATCH = 3'd1,
        S_DELAY      = 3'd2,
        S_DONE_PASS  = 3'd3,
        S_DONE_FAIL  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CHK_W-1:0] r_expect [DEPTH];
    logic [CHK_W-1:0] r_resp   [DEPTH];
    logic [DLY_W-1:0] r_delay  [DEPTH];

    logic [AW:0]      r_num;
    logic [TMO_W-1:0] r_tmo_lat;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [DLY_W-1:0] r_dly_cnt;
    logic [AW-1:0]    r_step;
    logic [AW-1:0]    r_fail_step;
    logic [CHK_W-1:0] r_resp_lo;
    logic             r_resp_oe;
    logic             r_busy;
    logic             r_pass;
    logic             r_fail;

    logic             w_not_busy;
    logic             w_eq;
    logic             w_match;
    logic             w_last;

    assign w_not_busy = (r_state == S_IDLE) || (r_state == S_DONE_PASS) || (r_state == S_DONE_FAIL);
    assign w_eq       = (obs_hi == r_expect[r_step]);
    assign w_last     = (({1'b0, r_step} + NUM_ONE) == r_num);

`ifdef CHKSEQ_STABLE_EN
    logic r_eq_prev;

    // Remember whether the previous waiting edge already saw a match; cleared outside WAIT_MATCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_eq_prev <= 1'b0;
        end else if (r_state == S_WAIT_MATCH) begin
            r_eq_prev <= w_eq;
        end else begin
            r_eq_prev <= 1'b0;
        end
    end

    assign w_match = w_eq & r_eq_prev;
`else
    assign w_match = w_eq;
`endif

    // Table write port; contents survive reset and are frozen while a sequence runs.
    always_ff @(posedge clock) begin
        if (prog_we && w_not_busy) begin
            r_expect[prog_addr] <= prog_expect;
            r_resp[prog_addr]   <= prog_resp;
            r_delay[prog_addr]  <= prog_delay;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_num       <= NUM_ZERO;
            r_tmo_lat   <= TMO_ZERO;
            r_tmo_cnt   <= TMO_ZERO;
            r_dly_cnt   <= DLY_ZERO;
            r_step      <= STEP_ZERO;
            r_fail_step <= STEP_ZERO;
            r_resp_lo   <= CHK_ZERO;
            r_resp_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE_PASS, S_DONE_FAIL: begin
                    if (start) begin
                        r_step <= STEP_ZERO;
                        r_fail <= 1'b0;
                        if (num_steps == NUM_ZERO) begin
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE_PASS;
                        end else begin
                            r_num     <= num_steps;
                            r_tmo_lat <= timeout;
                            r_tmo_cnt <= timeout;
                            r_pass    <= 1'b0;
                            r_resp_oe <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_WAIT_MATCH;
                        end
                    end
                end
                S_WAIT_MATCH: begin
                    // A match on the same edge as expiry wins over the timeout.
                    if (w_match) begin
                        r_dly_cnt <= r_delay[r_step];
                        r_state   <= S_DELAY;
                    end else if (r_tmo_lat != TMO_ZERO) begin
                        if (r_tmo_cnt == TMO_ZERO) begin
                            r_fail      <= 1'b1;
                            r_fail_step <= r_step;
                            r_busy      <= 1'b0;
                            r_state     <= S_DONE_FAIL;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt - TMO_ONE;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt != DLY_ZERO) begin
                        r_dly_cnt <= r_dly_cnt - DLY_ONE;
                    end else begin
                        r_resp_lo <= r_resp[r_step];
                        r_resp_oe <= 1'b1;
                        if (w_last) begin
                            r_pass  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE_PASS;
                        end else begin
                            r_step    <= r_step + STEP_ONE;
                            r_tmo_cnt <= r_tmo_lat;
                            r_state   <= S_WAIT_MATCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_lo   = r_resp_lo;
    assign resp_oe   = r_resp_oe;
    assign busy      = r_busy;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_step = r_fail_step;
    assign step      = r_step;

endmodule

// File: tb/tb_gpio_checkpoint_seq.sv
// Randomized self-checking bench for gpio_checkpoint_seq; predicts response timing from
// table contents and the match/delay/timeout rules.
module tb_gpio_checkpoint_seq;

    localparam int CHK_W = 8;
    localparam int DEPTH = 16;
    localparam int DLY_W = 12;
    localparam int TMO_W = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef CHKSEQ_STABLE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [CHK_W-1:0] prog_expect;
    logic [CHK_W-1:0] prog_resp;
    logic [DLY_W-1:0] prog_delay;
    logic [AW:0]      num_steps;
    logic [TMO_W-1:0] timeout;
    logic             start;
    logic [CHK_W-1:0] obs_hi;
    logic [CHK_W-1:0] resp_lo;
    logic             resp_oe;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [AW-1:0]    fail_step;
    logic [AW-1:0]    step;

    gpio_checkpoint_seq #(.CHK_W(CHK_W), .DEPTH(DEPTH), .DLY_W(DLY_W), .TMO_W(TMO_W)) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_expect(prog_expect), .prog_resp(prog_resp), .prog_delay(prog_delay),
        .num_steps(num_steps), .timeout(timeout), .start(start), .obs_hi(obs_hi),
        .resp_lo(resp_lo), .resp_oe(resp_oe), .busy(busy), .pass(pass), .fail(fail),
        .fail_step(fail_step), .step(step)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [CHK_W-1:0] m_exp  [DEPTH];
    logic [CHK_W-1:0] m_resp [DEPTH];
    int               m_dly  [DEPTH];
    logic [CHK_W-1:0] m_lo;
    logic             m_oe;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int e_busy, input int e_step,
                               input int e_pass, input int e_fail);
        check_eq({tag, ".busy"},    32'(busy),    32'(e_busy));
        check_eq({tag, ".step"},    32'(step),    32'(e_step));
        check_eq({tag, ".pass"},    32'(pass),    32'(e_pass));
        check_eq({tag, ".fail"},    32'(fail),    32'(e_fail));
        check_eq({tag, ".resp_lo"}, 32'(resp_lo), 32'(m_lo));
        check_eq({tag, ".resp_oe"}, 32'(resp_oe), 32'(m_oe));
    endtask

    task automatic prog_entry(input int a, input logic [CHK_W-1:0] e,
                              input logic [CHK_W-1:0] r, input int d);
        prog_addr   = AW'(a);
        prog_expect = e;
        prog_resp   = r;
        prog_delay  = DLY_W'(d);
        prog_we     = 1'b1;
        tick();
        prog_we     = 1'b0;
        m_exp[a]  = e;
        m_resp[a] = r;
        m_dly[a]  = d;
    endtask

    task automatic do_start(input int n, input int tmo);
        num_steps = (AW+1)'(n);
        timeout   = TMO_W'(tmo);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // One full sequence: n steps, stall forever at step stall_at (needs tmo>0),
    // bgap>=0 forces the first step's idle gap, disturb pokes start/prog_we while busy.
    task automatic run_seq(input int n, input int tmo, input int stall_at,
                           input int bgap, input bit disturb);
        obs_hi = m_exp[0] ^ 8'h5A;
        do_start(n, tmo);
        m_oe = 1'b0;
        check_state("start", 1, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            logic [CHK_W-1:0] idle_v;
            int gap;
            int lat;
            bit glitch;
            idle_v = m_exp[i] ^ 8'h5A;
            if (i == stall_at) begin
                for (int k = 1; k <= tmo + 1; k++) begin
                    obs_hi = idle_v;
                    tick();
                    if (k <= tmo) check_state("stall", 1, i, 0, 0);
                    else begin
                        check_state("timeout", 0, i, 0, 1);
                        check_eq("fail_step", 32'(fail_step), 32'(i));
                    end
                end
                return;
            end
            gap    = (i == 0 && bgap >= 0) ? bgap : int'($urandom_range(0, 8));
            glitch = (EXTRA == 1) && (gap >= 2) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < gap; k++) begin
                obs_hi = (glitch && k == gap - 2) ? m_exp[i] : idle_v;
                if (disturb && i == 1 && k == 0) begin
                    prog_addr   = AW'(0);
                    prog_expect = ~m_exp[0];
                    prog_resp   = ~m_resp[0];
                    prog_delay  = DLY_W'($urandom_range(0, 50));
                    prog_we     = 1'b1;
                    start       = 1'b1;
                    num_steps   = (AW+1)'($urandom_range(0, DEPTH));
                    timeout     = TMO_W'($urandom_range(1, 3));
                end
                tick();
                prog_we = 1'b0;
                start   = 1'b0;
                check_state("gap", 1, i, 0, 0);
            end
            obs_hi = m_exp[i];
            lat = m_dly[i] + 2 + EXTRA;
            for (int k = 1; k <= lat; k++) begin
                tick();
                if (k < lat) check_state("delay", 1, i, 0, 0);
                else begin
                    m_lo = m_resp[i];
                    m_oe = 1'b1;
                    if (i == n - 1) check_state("pass", 0, i, 1, 0);
                    else check_state("resp", 1, i + 1, 0, 0);
                end
            end
        end
    endtask

    task automatic prog_random(input int n);
        for (int a = 0; a < n; a++) begin
            prog_entry(a, 8'($urandom), 8'($urandom), int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_expect = '0; prog_resp = '0;
        prog_delay = '0; num_steps = '0; timeout = '0; start = 1'b0; obs_hi = '0;
        m_lo = '0; m_oe = 1'b0;
        tick(); tick();
        check_state("reset", 0, 0, 0, 0);
        check_eq("reset.fail_step", 32'(fail_step), 32'(0));
        reset = 1'b0;
        tick();

        do_start(0, 0);
        check_state("zero_steps", 0, 0, 1, 0);

        prog_entry(0, 8'hA0, 8'hF0, 0);
        prog_entry(1, 8'h0B, 8'h0F, 0);
        prog_entry(2, 8'hAB, 8'h00, 1000);
        run_seq(3, 0, 99, 0, 1'b0);
        run_seq(3, 50, 0, -1, 1'b0);

        // Reset in the middle of step 1's delay.
        prog_entry(1, 8'h0B, 8'h0F, 300);
        obs_hi = 8'hA0;
        do_start(3, 0);
        m_oe = 1'b0;
        for (int k = 0; k < 2 + EXTRA; k++) tick();
        m_lo = 8'hF0; m_oe = 1'b1;
        check_state("mid.step1", 1, 1, 0, 0);
        obs_hi = 8'h0B;
        for (int k = 0; k < 10; k++) tick();
        check_state("mid.delay", 1, 1, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_lo = '0; m_oe = 1'b0;
        check_state("mid.reset", 0, 0, 0, 0);
        prog_entry(1, 8'h0B, 8'h0F, 2);
        run_seq(3, 0, 99, -1, 1'b1);
        run_seq(3, 0, 99, -1, 1'b0);

        // Match on the very edge the timeout would expire.
        run_seq(3, 20, 99, 20 - EXTRA, 1'b0);

        prog_random(DEPTH);
        run_seq(DEPTH, 0, 99, -1, 1'b1);
        run_seq(DEPTH, 30, DEPTH - 1, -1, 1'b0);

        for (int it = 0; it < 10; it++) begin
            int n;
            int tmo;
            int stall;
            n = int'($urandom_range(1, DEPTH));
            prog_random(n);
            tmo   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(15, 40)) : 0;
            stall = (tmo != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : 99;
            run_seq(n, tmo, stall, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
